// File: rtl/f_ifu_fd_if.sv
// Fetch/decode boundary bundle: hazard controls, D-stage redirect, IM port and F/D register outputs.
// The slave side is the fetch block; the master side is its surroundings (hazard unit, D stage, IM).
interface f_ifu_fd_if;
    localparam int unsigned XLEN = 32;

    logic            stall;
    logic            flush;
    logic            D_jump;
    logic [XLEN-1:0] D_npc;
    logic [XLEN-1:0] i_inst_rdata;
    logic [XLEN-1:0] i_inst_addr;
    logic [XLEN-1:0] F_PC;
    logic [XLEN-1:0] D_PC;
    logic [XLEN-1:0] D_PC4;
    logic [XLEN-1:0] D_instr;
    logic            D_valid;
    logic            D_exc_adel;

    modport master (
        output stall, flush, D_jump, D_npc, i_inst_rdata,
        input  i_inst_addr, F_PC, D_PC, D_PC4, D_instr, D_valid, D_exc_adel
    );

    modport slave (
        input  stall, flush, D_jump, D_npc, i_inst_rdata,
        output i_inst_addr, F_PC, D_PC, D_PC4, D_instr, D_valid, D_exc_adel
    );
endinterface

// File: rtl/f_ifu_fd.sv
// Fetch-stage PC register and F/D pipeline register with AdEL fetch-error tagging.
// Delay slots are never squashed here; flush/stall come from the hazard unit.
module f_ifu_fd #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    f_ifu_fd_if.slave     bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = XLEN + 1;
    // Upper bound kept in 33 bits so a memory ending at 4 GiB cannot wrap.
    localparam logic [AW-1:0] IM_LIMIT = AW'(IM_BASE) + (AW'(IM_WORDS) << 2);

    logic [XLEN-1:0] f_pc_q;
    logic [XLEN-1:0] d_pc_q;
    logic [XLEN-1:0] d_pc4_q;
    logic [XLEN-1:0] d_instr_q;
    logic            d_valid_q;
    logic            d_exc_adel_q;

    logic [XLEN-1:0] f_pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic            fetch_err;

    // Next-PC selection and fetch address check.
    always_comb begin
        f_pc_plus4 = f_pc_q + XLEN'(4);
        pc_next    = bus.D_jump ? bus.D_npc : f_pc_plus4;
        fetch_err  = (f_pc_q[1:0] != 2'b00)
                   || (f_pc_q < IM_BASE)
                   || ({1'b0, f_pc_q} >= IM_LIMIT);
    end

    // F_PC follows stall only; flush does not affect fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= RESET_PC;
        end else if (!bus.stall) begin
            f_pc_q <= pc_next;
        end
    end

    // F/D register: flush beats stall, a bubble still records the squashed PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc_q       <= RESET_PC;
            d_pc4_q      <= RESET_PC + XLEN'(4);
            d_instr_q    <= '0;
            d_valid_q    <= 1'b0;
            d_exc_adel_q <= 1'b0;
        end else if (bus.flush) begin
            d_pc_q       <= f_pc_q;
            d_pc4_q      <= f_pc_plus4;
            d_instr_q    <= '0;
            d_valid_q    <= 1'b0;
            d_exc_adel_q <= 1'b0;
        end else if (!bus.stall) begin
            d_pc_q       <= f_pc_q;
            d_pc4_q      <= f_pc_plus4;
            d_instr_q    <= fetch_err ? '0 : bus.i_inst_rdata;
            d_valid_q    <= 1'b1;
            d_exc_adel_q <= fetch_err;
        end
    end

    assign bus.i_inst_addr = f_pc_q;
    assign bus.F_PC        = f_pc_q;
    assign bus.D_PC        = d_pc_q;
    assign bus.D_PC4       = d_pc4_q;
    assign bus.D_instr     = d_instr_q;
    assign bus.D_valid     = d_valid_q;
    assign bus.D_exc_adel  = d_exc_adel_q;
endmodule

// File: tb/tb_f_ifu_fd.sv
// Self-checking bench for f_ifu_fd: directed plan steps followed by random
// stall/flush/redirect traffic, all compared against a reference model.
module tb_f_ifu_fd;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int unsigned WORDS = 4096;

    logic clk;
    logic reset;
    f_ifu_fd_if bus ();

    f_ifu_fd #(
        .RESET_PC (32'h0000_3000),
        .IM_BASE  (BASE),
        .IM_WORDS (WORDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words from the plan, a pattern elsewhere.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0001;
        if (a == 32'h0000_3004) return 32'h2409_0002;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3} | 32'h1;
    endfunction

    assign bus.i_inst_rdata = im_word(bus.i_inst_addr);

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return (la % 4 != 0) || (la < longint'(BASE)) ||
               (la >= longint'(BASE) + 4 * longint'(WORDS));
    endfunction

    // Reference model state.
    logic [31:0] m_fpc, m_dpc, m_dpc4, m_dinstr;
    logic        m_dvalid, m_dexc;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic st, input logic fl,
                              input logic jp, input logic [31:0] npc);
        logic [31:0] nf;
        if (rst) begin
            m_fpc = 32'h0000_3000; m_dpc = 32'h0000_3000; m_dpc4 = 32'h0000_3004;
            m_dinstr = '0; m_dvalid = 1'b0; m_dexc = 1'b0;
        end else begin
            nf = st ? m_fpc : (jp ? npc : m_fpc + 32'd4);
            if (fl) begin
                m_dpc = m_fpc; m_dpc4 = m_fpc + 32'd4;
                m_dinstr = '0; m_dvalid = 1'b0; m_dexc = 1'b0;
            end else if (!st) begin
                m_dpc = m_fpc; m_dpc4 = m_fpc + 32'd4; m_dvalid = 1'b1;
                m_dexc = addr_bad(m_fpc);
                m_dinstr = m_dexc ? 32'h0 : im_word(m_fpc);
            end
            m_fpc = nf;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".F_PC"},        bus.F_PC,              m_fpc);
        chk({tag, ".i_inst_addr"}, bus.i_inst_addr,       m_fpc);
        chk({tag, ".D_PC"},        bus.D_PC,              m_dpc);
        chk({tag, ".D_PC4"},       bus.D_PC4,             m_dpc4);
        chk({tag, ".D_instr"},     bus.D_instr,           m_dinstr);
        chk({tag, ".D_valid"},     32'(bus.D_valid),      32'(m_dvalid));
        chk({tag, ".D_exc_adel"},  32'(bus.D_exc_adel),   32'(m_dexc));
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic cycle(input string tag, input logic rst, input logic st, input logic fl,
                         input logic jp, input logic [31:0] npc);
        reset = rst; bus.stall = st; bus.flush = fl; bus.D_jump = jp; bus.D_npc = npc;
        @(posedge clk);
        model_step(rst, st, fl, jp, npc);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic st, fl, jp, rs;
        logic [31:0] npc;
        reset = 1'b1; bus.stall = 0; bus.flush = 0; bus.D_jump = 0; bus.D_npc = '0;
        m_fpc = '0; m_dpc = '0; m_dpc4 = '0; m_dinstr = '0; m_dvalid = 0; m_dexc = 0;
        @(negedge clk);

        cycle("reset", 1, 0, 0, 0, 32'h0);
        chk("reset.F_PC_const", bus.F_PC, 32'h0000_3000);
        chk("reset.D_PC4_const", bus.D_PC4, 32'h0000_3004);

        cycle("seq0", 0, 0, 0, 0, 32'h0);
        chk("seq0.D_instr_const", bus.D_instr, 32'h2408_0001);
        chk("seq0.F_PC_const", bus.F_PC, 32'h0000_3004);
        cycle("seq1", 0, 0, 0, 0, 32'h0);
        chk("seq1.D_instr_const", bus.D_instr, 32'h2409_0002);
        chk("seq1.F_PC_const", bus.F_PC, 32'h0000_3008);

        cycle("redir", 0, 0, 0, 1, 32'h0000_3040);
        chk("redir.F_PC_const", bus.F_PC, 32'h0000_3040);
        chk("redir.delay_slot_PC", bus.D_PC, 32'h0000_3008);
        cycle("redir1", 0, 0, 0, 0, 32'h0);
        chk("redir1.F_PC_const", bus.F_PC, 32'h0000_3044);

        cycle("to3010", 0, 0, 0, 1, 32'h0000_3010);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 0, 1, 0, 1, 32'h0000_3100);
            chk("stall.F_PC_const", bus.F_PC, 32'h0000_3010);
            chk("stall.D_PC_const", bus.D_PC, 32'h0000_3044);
        end
        cycle("unstall", 0, 0, 0, 1, 32'h0000_3100);
        chk("unstall.F_PC_const", bus.F_PC, 32'h0000_3100);

        cycle("to3020", 0, 0, 0, 1, 32'h0000_3020);
        cycle("flush_stall", 0, 1, 1, 0, 32'h0);
        chk("flush_stall.F_PC_const", bus.F_PC, 32'h0000_3020);
        chk("flush_stall.D_PC_const", bus.D_PC, 32'h0000_3020);
        chk("flush_stall.D_valid_const", 32'(bus.D_valid), 32'd0);

        cycle("to3002", 0, 0, 0, 1, 32'h0000_3002);
        cycle("to7000", 0, 0, 0, 1, 32'h0000_7000);
        chk("misalign.adel_const", 32'(bus.D_exc_adel), 32'd1);
        chk("misalign.D_PC_const", bus.D_PC, 32'h0000_3002);
        cycle("to6ffc", 0, 0, 0, 1, 32'h0000_6FFC);
        chk("past_end.adel_const", 32'(bus.D_exc_adel), 32'd1);
        cycle("last_word", 0, 0, 0, 0, 32'h0);
        chk("last_word.adel_const", 32'(bus.D_exc_adel), 32'd0);

        cycle("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle("wrap", 0, 0, 0, 0, 32'h0);
        chk("wrap.F_PC_const", bus.F_PC, 32'h0000_0000);
        chk("wrap.adel_top", 32'(bus.D_exc_adel), 32'd1);
        cycle("wrap1", 0, 0, 0, 0, 32'h0);
        chk("wrap1.adel_zero", 32'(bus.D_exc_adel), 32'd1);

        cycle("stall_pre", 0, 1, 0, 1, 32'h0000_3200);
        cycle("mid_reset", 1, 1, 1, 1, 32'h0000_3200);
        chk("mid_reset.F_PC_const", bus.F_PC, 32'h0000_3000);
        chk("mid_reset.D_valid_const", 32'(bus.D_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rs = ($urandom % 50) == 0;
            st = ($urandom % 4) == 0;
            fl = ($urandom % 8) == 0;
            jp = ($urandom % 4) == 0;
            case ($urandom % 8)
                0:       npc = $urandom;
                1:       npc = BASE + 32'(4 * WORDS) - 32'(4 * $urandom_range(0, 1));
                2:       npc = BASE - 32'd4;
                default: npc = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            endcase
            cycle("rand", rs, st, fl, jp, npc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/f_ifu_fd.md
Name: f_ifu_fd

Overview:
- Fetch-stage program counter register plus F/D pipeline register.
- Holds F_PC, drives the instruction-memory address, and latches {PC, instruction, status} into the D stage.
- D-stage next-PC logic consumes D_PC and D_instr fields and returns a redirect target (D_npc, D_jump) to this block.
- Detects fetch address errors and tags them into D.

Parameters:
RESET_PC, 32'h0000_3000, F_PC value after reset.
IM_BASE, 32'h0000_3000, lowest legal instruction byte address.
IM_WORDS, 4096, instruction memory depth in 32-bit words; legal range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard-unit stall; freezes F_PC and the F/D register.
flush  input  1  clears the F/D register to a bubble.
D_jump  input  1  D stage has a taken branch or jump this cycle.
D_npc  input  32  redirect target from D-stage next-PC logic.
i_inst_rdata  input  32  instruction word from IM (combinational read of i_inst_addr).
i_inst_addr  output  32  IM byte address, equal to F_PC.
F_PC  output  32  current fetch PC.
D_PC  output  32  PC of the instruction in D.
D_PC4  output  32  D_PC + 4.
D_instr  output  32  instruction in D (0 = nop).
D_valid  output  1  D holds a real fetched instruction (not a reset or flush bubble).
D_exc_adel  output  1  D instruction faulted on fetch (ExcCode 4, AdEL).

Behaviour:
- Reset (sync, priority over everything):
  - F_PC = RESET_PC.
  - D_PC = RESET_PC, D_PC4 = RESET_PC + 4.
  - D_instr = 0, D_valid = 0, D_exc_adel = 0.
- Next-PC selection: pc_next = D_jump ? D_npc : F_PC + 4.
  - Arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Branch delay slot: the instruction fetched in the same cycle D_jump=1 is the delay slot.
  - It is latched into D normally and not squashed by this block.
- F_PC update:
  - stall=0: F_PC <= pc_next.
  - stall=1: F_PC holds, and D_jump/D_npc are ignored that cycle.
  - The hazard unit keeps D_jump asserted until stall deasserts.
- F/D register, per cycle, in priority order:
  1. reset.
  2. flush=1: D_instr <= 0, D_valid <= 0, D_exc_adel <= 0, D_PC <= F_PC, D_PC4 <= F_PC + 4.
     - flush wins over stall for the F/D register.
     - F_PC still follows stall only.
  3. stall=1: all D_* outputs hold.
  4. Otherwise: D_PC <= F_PC, D_PC4 <= F_PC + 4, D_valid <= 1, D_exc_adel <= fetch_err, D_instr <= fetch_err ? 0 : i_inst_rdata.
- Fetch error definition: fetch_err = (F_PC[1:0] != 0) OR F_PC < IM_BASE OR F_PC >= IM_BASE + 4*IM_WORDS.
  - Compare unsigned; compute the upper bound in 33 bits to avoid overflow.
- i_inst_addr = F_PC at all times, including error cycles.
  - The IM is read-only with no side effects, so out-of-range reads are harmless; their data is discarded.
- Latency:
  - Instruction at F_PC appears on D_instr one cycle after fetch, absent stall/flush.
  - A redirect presented in cycle n sets F_PC = D_npc in cycle n+1.
- No combinational path from any input to D_* outputs.
  - The only combinational path is from the F_PC register to i_inst_addr.

Test Plan:
- Reset then release; IM returns 32'h2408_0001 at 0x3000 and 32'h2409_0002 at 0x3004 -> F_PC goes 0x3000, 0x3004, 0x3008. D_PC/D_instr are 0x3000/24080001 then 0x3004/24090002, with D_valid=1 from the first post-reset edge.
- Redirect: D_jump=1, D_npc=0x0000_3040 for one cycle while F_PC=0x3008 -> delay slot at 0x3008 enters D. Next F_PC = 0x3040, then 0x3044.
- Stall for 3 cycles at F_PC=0x3010, with D_jump=1 and D_npc=0x3100 asserted throughout -> F_PC and all D_* frozen for 3 cycles. After stall drops, F_PC = 0x3100.
- Flush with stall=1 at F_PC=0x3020 -> next cycle D_instr=0, D_valid=0, D_PC=0x3020, F_PC still 0x3020.
- Fetch errors:
  - D_npc=0x0000_3002 -> D_exc_adel=1, D_instr=0, D_PC=0x3002.
  - D_npc=0x0000_7000 (IM_WORDS=4096, one past the end) -> D_exc_adel=1.
  - D_npc=0x0000_6FFC -> D_exc_adel=0.
- Wrap and mid-run reset:
  - F_PC forced via D_npc=0xFFFF_FFFC -> next F_PC = 0x0000_0000, both fetches flag AdEL.
  - Reset asserted mid-stall -> next edge restores all reset values regardless of stall/flush.
